// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// The CPU request is latched on each unstalled edge and resolved against the arrays the following cycle.
module dcache_responder #(
  parameter int INDEX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall,
  output logic        mem_req_valid,
  output logic        mem_req_rnw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t state, state_nxt;

  logic [29:0]         pend_word;
  logic                pend_re;
  logic [3:0]          pend_we;
  logic [31:0]         pend_din;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];
  logic [31:0]         fill_q;
  logic [31:0]         dout_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  wr_pend;
  logic                  wr_fire;
  logic                  fill;
  logic                  unused_addr_lsbs;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    merge_bytes = old_w;
    for (int i = 0; i < 4; i++)
      if (mask[i]) merge_bytes[8*i +: 8] = new_w[8*i +: 8];
  endfunction

  assign idx              = pend_word[INDEX_BITS-1:0];
  assign tag              = pend_word[29:INDEX_BITS];
  assign hit              = valid[idx] && (tag_mem[idx] == tag);
  assign wr_pend          = (pend_we != 4'b0000);
  assign wr_fire          = (state == IDLE) && wr_pend && mem_req_ready && !rst;
  assign fill             = (state == RD_WAIT) && mem_resp_valid && !rst;
  assign unused_addr_lsbs = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_re && !hit) state_nxt = RD_REQ;
      RD_REQ:  if (mem_req_ready)   state_nxt = RD_WAIT;
      RD_WAIT: if (mem_resp_valid)  state_nxt = RD_DONE;
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // dout falls back to the last value it drove whenever no read completes this cycle.
  always_comb begin
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rnw   = 1'b1;
    mem_req_addr  = 32'h0;
    mem_req_data  = 32'h0;
    mem_req_mask  = 4'b0000;
    dout          = dout_q;
    case (state)
      IDLE: begin
        if (wr_pend) begin
          mem_req_valid = 1'b1;
          mem_req_rnw   = 1'b0;
          mem_req_addr  = {pend_word, 2'b00};
          mem_req_data  = pend_din;
          mem_req_mask  = pend_we;
          stall         = ~mem_req_ready;
        end else if (pend_re) begin
          if (hit) dout  = data_mem[idx];
          else     stall = 1'b1;
        end
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {pend_word, 2'b00};
        stall         = 1'b1;
      end
      RD_WAIT: stall = 1'b1;
      RD_DONE: dout  = fill_q;
      default: ;
    endcase
  end

  // control state: pending kind, line valid bits, held read data
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_re <= 1'b0;
      pend_we <= 4'b0000;
      valid   <= '0;
      dout_q  <= 32'h0;
    end else begin
      dout_q <= dout;
      if (!stall) begin
        pend_re <= re && (we == 4'b0000);
        pend_we <= we;
      end
      if (fill) valid[idx] <= 1'b1;
    end
  end

  // datapath: request payload and arrays, never reset
  always_ff @(posedge clk) begin
    if (!stall) begin
      pend_word <= addr[31:2];
      pend_din  <= din;
    end
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_resp_data;
      fill_q        <= mem_resp_data;
    end else if (wr_fire && hit) begin
      data_mem[idx] <= merge_bytes(data_mem[idx], pend_din, pend_we);
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: a scripted vector table, two multi-cycle sequences and a random phase,
// all checked against a word-addressed backing memory and a line-presence model kept here.
module tb_dcache_responder;

  localparam int TMO = 500;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_rnw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  dcache_responder #(.INDEX_BITS(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .din(din),
    .dout(dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // backing memory and its traffic log
  logic [31:0] mem [logic [29:0]];
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] last_rd_addr = 32'h0;
  int          lat = 1;
  int          rdy_mode = 0;
  int          rdy_hold = 0;
  int          resp_cnt = -1;
  logic [29:0] resp_word = 30'h0;

  // which lines should be present, from read-miss fills only
  bit          m_valid [256];
  logic [21:0] m_tag   [256];

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] apply_mask(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[9:2]] && (m_tag[a[9:2]] == a[31:10]);
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    m_valid[a[9:2]] = 1'b1;
    m_tag[a[9:2]]   = a[31:10];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // memory side: acts on falling edges so the DUT sees settled ready/response at the next rise
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (rst) begin
        resp_cnt = -1;
      end else if (resp_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(resp_word);
        resp_cnt       = -1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
      end
      if (rdy_hold > 0) begin
        mem_req_ready = 1'b0;
        rdy_hold--;
      end else if (rdy_mode == 1) begin
        mem_req_ready = ($urandom_range(0, 1) == 1);
      end else begin
        mem_req_ready = 1'b1;
      end
      if (!rst && mem_req_valid && mem_req_ready) begin
        if (mem_req_rnw) begin
          n_rd++;
          last_rd_addr = mem_req_addr;
          resp_word    = mem_req_addr[31:2];
          resp_cnt     = lat - 1;
        end else begin
          n_wr++;
          mem[mem_req_addr[31:2]] = apply_mask(mem_word(mem_req_addr[31:2]), mem_req_data, mem_req_mask);
        end
      end
    end
  end

  // One CPU access; entered and left just after a falling edge.
  task automatic cpu_op(input logic [31:0] a, input logic r, input logic [3:0] w, input logic [31:0] d,
                        output logic [31:0] q, output int stalls, output int nrd, output int nwr,
                        output int badf);
    int rd0, wr0, guard;
    stalls = 0; badf = 0; q = 32'h0; guard = 0;
    addr = a; re = r; we = w; din = d;
    while (stall !== 1'b0 && guard < TMO) begin
      @(negedge clk); #1; guard++;
    end
    rd0 = n_rd; wr0 = n_wr;
    @(negedge clk); #1;
    addr = $urandom; re = 1'b0; we = 4'b0000; din = $urandom;
    if (w != 4'b0000 || r) begin
      while (stall !== 1'b0 && guard < TMO) begin
        if (w != 4'b0000 && !(mem_req_valid === 1'b1 && mem_req_rnw === 1'b0 &&
            mem_req_addr === {a[31:2], 2'b00} && mem_req_data === d && mem_req_mask === w))
          badf++;
        stalls++;
        @(negedge clk); #1; guard++;
      end
      if (w != 4'b0000) begin
        if (!(mem_req_valid === 1'b1 && mem_req_rnw === 1'b0 && mem_req_addr === {a[31:2], 2'b00} &&
              mem_req_data === d && mem_req_mask === w))
          badf++;
      end else begin
        q = dout;
      end
    end
    if (guard >= TMO) begin
      n_checks++;
      $display("FAIL cpu_op_timeout: addr %h still stalled after %0d cycles, required under %0d", a, guard, TMO);
    end
    nrd = n_rd - rd0;
    nwr = n_wr - wr0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        r;
    logic [3:0]  w;
    logic [31:0] d;
    int          lat;
    logic [31:0] q;
    int          nrd;
    int          nwr;
    int          stalls;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] q, a, d;
    logic [3:0]  w;
    logic        r, exp_hit;
    int          stalls, nrd, nwr, badf, guard, rd0, op;
    string       nm;

    rst = 1'b1; addr = 32'h0; re = 1'b0; we = 4'b0000; din = 32'h0;
    model_clear();
    mem[30'h10000040 >> 2] = 32'hDEADBEEF;
    mem[30'h10000440 >> 2] = 32'h12345678;

    vecs[0] = '{32'h10000040, 1'b1, 4'b0000, 32'h0,        3, 32'hDEADBEEF, 1, 0, 5};
    vecs[1] = '{32'h10000040, 1'b1, 4'b0000, 32'h0,        1, 32'hDEADBEEF, 0, 0, 0};
    vecs[2] = '{32'h10000040, 1'b0, 4'b0011, 32'h0000CAFE, 1, 32'h0,        0, 1, 0};
    vecs[3] = '{32'h10000040, 1'b1, 4'b0000, 32'h0,        1, 32'hDEADCAFE, 0, 0, 0};
    vecs[4] = '{32'h10000440, 1'b1, 4'b0000, 32'h0,        2, 32'h12345678, 1, 0, 4};
    vecs[5] = '{32'h10000040, 1'b1, 4'b0000, 32'h0,        1, 32'hDEADCAFE, 1, 0, 3};
    vecs[6] = '{32'h10000040, 1'b1, 4'b1000, 32'hAB000000, 1, 32'h0,        0, 1, 0};
    vecs[7] = '{32'h10000040, 1'b1, 4'b0000, 32'h0,        1, 32'hABADCAFE, 0, 0, 0};
    vecs[8] = '{32'h10000440, 1'b1, 4'b0000, 32'h0,        1, 32'h12345678, 1, 0, 3};

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check("rst_req_rnw", {31'b0, mem_req_rnw}, 32'h1);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_req_data", mem_req_data, 32'h0);
    check("rst_req_mask", {28'b0, mem_req_mask}, 32'h0);
    check("rst_dout", dout, 32'h0);

    for (int i = 0; i < 9; i++) begin
      lat = vecs[i].lat;
      cpu_op(vecs[i].a, vecs[i].r, vecs[i].w, vecs[i].d, q, stalls, nrd, nwr, badf);
      if (vecs[i].r && vecs[i].w == 4'b0000) begin
        model_fill(vecs[i].a);
        check($sformatf("vec%0d_dout", i), q, vecs[i].q);
      end else begin
        check($sformatf("vec%0d_wfields", i), badf, 0);
      end
      check($sformatf("vec%0d_mem_reads", i), nrd, vecs[i].nrd);
      check($sformatf("vec%0d_mem_writes", i), nwr, vecs[i].nwr);
      check($sformatf("vec%0d_stalls", i), stalls, vecs[i].stalls);
      if (vecs[i].nrd == 1) check($sformatf("vec%0d_rd_addr", i), last_rd_addr, {vecs[i].a[31:2], 2'b00});
    end

    // write miss while memory holds ready low for two cycles
    rdy_hold = 2;
    cpu_op(32'h10000080, 1'b0, 4'b1100, 32'h5A5A0000, q, stalls, nrd, nwr, badf);
    check("wmiss_stalls", stalls, 2);
    check("wmiss_fields_stable", badf, 0);
    check("wmiss_mem_writes", nwr, 1);
    lat = 2;
    cpu_op(32'h10000080, 1'b1, 4'b0000, 32'h0, q, stalls, nrd, nwr, badf);
    model_fill(32'h10000080);
    check("wmiss_then_read_misses", nrd, 1);
    check("wmiss_then_read_dout", q, apply_mask(({2'b00, 30'h10000080 >> 2} * 32'h9E3779B1) ^ 32'h5A5A1234,
                                                 32'h5A5A0000, 4'b1100));

    // reset while waiting for a fill response
    lat = 6; guard = 0; rd0 = n_rd;
    addr = 32'h10000040; re = 1'b1; we = 4'b0000;
    @(negedge clk); #1;
    re = 1'b0;
    while (n_rd == rd0 && guard < TMO) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= TMO) begin
      n_checks++;
      $display("FAIL rstmid_no_request: no memory read after %0d cycles, required one", guard);
    end
    @(negedge clk); #1;
    check("rstmid_wait_stall", {31'b0, stall}, 32'h1);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("rstmid_stall", {31'b0, stall}, 32'h0);
    check("rstmid_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check("rstmid_dout", dout, 32'h0);
    lat = 2;
    cpu_op(32'h10000040, 1'b1, 4'b0000, 32'h0, q, stalls, nrd, nwr, badf);
    model_fill(32'h10000040);
    check("rstmid_reread_misses", nrd, 1);
    check("rstmid_reread_dout", q, 32'hABADCAFE);

    // random traffic over a few aliasing lines, random ready and latency
    rdy_mode = 1;
    for (int k = 0; k < 200; k++) begin
      op = $urandom_range(0, 9);
      a = 32'h10000000 + ($urandom_range(0, 3) << 10) + $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: a = a + (32'h10 << 2);
        1: a = a + (32'h11 << 2);
        2: a = a + (32'hFF << 2);
        default: ;
      endcase
      r = (op < 5) || (op == 9);
      w = (op < 5) ? 4'b0000 : 4'($urandom_range(1, 15));
      d = $urandom;
      lat = $urandom_range(1, 4);
      exp_hit = model_hit(a);
      cpu_op(a, r, w, d, q, stalls, nrd, nwr, badf);
      nm = $sformatf("rnd%0d_a%h", k, a);
      if (w == 4'b0000) begin
        check({nm, "_dout"}, q, mem_word(a[31:2]));
        check({nm, "_rd_miss"}, nrd, exp_hit ? 0 : 1);
        model_fill(a);
      end else begin
        check({nm, "_wr"}, nwr, 1);
        check({nm, "_wr_no_rd"}, nrd, 0);
        check({nm, "_wfields"}, badf, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
